ir_fetch_decode: RTL and testbench
==================================

IR_FETCH_DECODE -- requirements
Module: ir_fetch_decode

Interface
REQ-001 The block SHALL have one parameter: MEM_TIMEOUT, default 15, the maximum number of FETCH cycles to wait for mem_ready.
REQ-002 The block SHALL have input clk, 1 bit, the single system clock.
REQ-003 The block SHALL have input rst, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have input fetch_req, 1 bit, which requests a fetch from pc.
REQ-005 The block SHALL have input pc, 16 bits, the fetch address.
REQ-006 The block SHALL have output mem_addr, 16 bits, a registered memory address.
REQ-007 The block SHALL have output mem_rd, 1 bit, a registered read strobe.
REQ-008 The block SHALL have input mem_rdata, 16 bits, the memory read data.
REQ-009 The block SHALL have input mem_ready, 1 bit, which marks mem_rdata valid in the current cycle.
REQ-010 The block SHALL have output ir, 16 bits, the instruction register.
REQ-011 The block SHALL have output opcode (4 bits, ir[15:12]), dr (3 bits, ir[11:9]) and nzp (3 bits, ir[11:9]).
REQ-012 The block SHALL have output sr1 (3 bits, ir[8:6]), sr2 (3 bits, ir[2:0]) and imm_flag (1 bit, ir[5]).
REQ-013 The block SHALL output the raw, unextended fields imm5 (ir[4:0]), offset6 (ir[5:0]), pcoffset9 (ir[8:0]), pcoffset11 (ir[10:0]) and trapvect8 (ir[7:0]) for the downstream sign/zero extenders.
REQ-014 The block SHALL have output dec_valid (1 bit, decoded fields valid), input dec_ready (1 bit, consumer accepts) and outputs busy and fetch_err (1 bit each).

Function
REQ-015 The FSM SHALL have three states: IDLE, FETCH and HOLD; busy SHALL be 1 when the state is FETCH or HOLD.
REQ-016 In IDLE with fetch_req=1, the next edge SHALL set mem_addr<=pc, mem_rd<=1, clear the wait counter and move to FETCH; with fetch_req=0 the block SHALL stay in IDLE.
REQ-017 In FETCH with mem_ready=1, the edge SHALL set ir<=mem_rdata, mem_rd<=0 and dec_valid<=1 and move to HOLD, giving 1-cycle minimum latency from mem_ready to dec_valid.
REQ-018 In FETCH with mem_ready=0, the wait counter SHALL increment by 1 each cycle.
REQ-019 When the wait counter equals MEM_TIMEOUT with mem_ready=0, the edge SHALL set fetch_err=1 for exactly one cycle, set mem_rd<=0, leave ir unchanged and move to IDLE.
REQ-020 If mem_ready=1 arrives in the timeout cycle, mem_ready SHALL win and no error SHALL be raised.
REQ-021 fetch_req SHALL be ignored in FETCH and in HOLD unless dec_ready=1 in the same cycle.
REQ-022 In HOLD, dec_valid and ir SHALL remain stable until dec_ready=1.
REQ-023 When dec_ready=1 in HOLD and fetch_req=0, the edge SHALL clear dec_valid and move to IDLE.
REQ-024 When dec_ready=1 and fetch_req=1 in the same HOLD cycle, the edge SHALL clear dec_valid, load mem_addr<=pc and mem_rd<=1, and move directly to FETCH (back-to-back fetch).
REQ-025 All decoded field outputs SHALL be pure bit-slices of the ir register, with no extension and no gating by dec_valid.
REQ-026 The wait counter SHALL be wide enough to hold MEM_TIMEOUT and SHALL never wrap.
REQ-027 dec_ready SHALL be ignored outside HOLD.

Reset
REQ-028 While rst=1 at a clock edge, the state SHALL return to IDLE and ir, mem_addr and the wait counter SHALL be 0; mem_rd, dec_valid, busy and fetch_err SHALL be 0.
REQ-029 A reset asserted mid-FETCH or mid-HOLD SHALL abort the operation with no fetch_err pulse, and any mem_rdata presented in that cycle SHALL be discarded.
REQ-030 rst SHALL take priority over every other input.

Structure
REQ-031 Opcode constants (OP_BR=0000, OP_ADD=0001, OP_AND=0101, OP_TRAP=1111, and so on) and the FSM state encoding SHALL live in the shared package lc3_pkg.
REQ-032 Field slicing SHALL be placed in one combinational sub-module, ir_field_split, instantiated once; the FSM, counter and registers SHALL stay in the top-level block.

Verification
REQ-033 Reset: assert rst for 2 cycles mid-FETCH -> all outputs are 0 and the state is IDLE, and a mem_ready=1 with data 16'h1234 in the reset cycle is not captured.
REQ-034 Basic fetch: pc=16'h3000, pulse fetch_req, mem_ready after 2 cycles with mem_rdata=16'h1261 -> mem_addr=3000 and mem_rd=1 during the wait, then ir=1261, opcode=0001, dr=1, sr1=1, imm_flag=1, imm5=5'b00001, dec_valid=1.
REQ-035 Hold/backpressure: keep dec_ready=0 for 5 cycles with mem_rdata changing -> ir and dec_valid stay stable, and one dec_ready pulse returns the block to IDLE the next cycle.
REQ-036 Back-to-back: dec_ready=1 and fetch_req=1 with pc=16'h3001 -> the next cycle is FETCH with mem_addr=3001 and dec_valid=0.
REQ-037 Timeout: MEM_TIMEOUT=15 with mem_ready held at 0 -> fetch_err pulses for exactly 1 cycle after 16 FETCH cycles, then IDLE, with ir unchanged.
REQ-038 Timeout tie: mem_ready=1 in the timeout cycle with data 16'hF025 -> ir=F025 and trapvect8=8'h25, with no fetch_err.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcode encodings and the fetch/decode FSM state type.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ir_fetch_decode_if.sv
// Fetch request, memory read bus and decoded-instruction handshake of ir_fetch_decode.
interface ir_fetch_decode_if;
    logic        fetch_req;
    logic [15:0] pc;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  nzp;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_flag;
    logic [4:0]  imm5;
    logic [5:0]  offset6;
    logic [8:0]  pcoffset9;
    logic [10:0] pcoffset11;
    logic [7:0]  trapvect8;
    logic        dec_valid;
    logic        dec_ready;
    logic        busy;
    logic        fetch_err;

    modport slave (
        input  fetch_req, pc, mem_rdata, mem_ready, dec_ready,
        output mem_addr, mem_rd, ir, opcode, dr, nzp, sr1, sr2, imm_flag,
               imm5, offset6, pcoffset9, pcoffset11, trapvect8,
               dec_valid, busy, fetch_err
    );

    modport master (
        output fetch_req, pc, mem_rdata, mem_ready, dec_ready,
        input  mem_addr, mem_rd, ir, opcode, dr, nzp, sr1, sr2, imm_flag,
               imm5, offset6, pcoffset9, pcoffset11, trapvect8,
               dec_valid, busy, fetch_err
    );
endinterface

// File: rtl/ir_field_split.sv
// Purpose: slice an LC-3 instruction word into its raw (unextended) fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow ir regardless of any valid qualifier.
module ir_field_split (
    input  logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [2:0]  dr,
    output logic [2:0]  nzp,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic        imm_flag,
    output logic [4:0]  imm5,
    output logic [5:0]  offset6,
    output logic [8:0]  pcoffset9,
    output logic [10:0] pcoffset11,
    output logic [7:0]  trapvect8
);
    // dr and nzp share bits 11:9; which one applies depends on the opcode downstream.
    assign opcode     = ir[15:12];
    assign dr         = ir[11:9];
    assign nzp        = ir[11:9];
    assign sr1        = ir[8:6];
    assign sr2        = ir[2:0];
    assign imm_flag   = ir[5];
    assign imm5       = ir[4:0];
    assign offset6    = ir[5:0];
    assign pcoffset9  = ir[8:0];
    assign pcoffset11 = ir[10:0];
    assign trapvect8  = ir[7:0];
endmodule

// File: rtl/ir_fetch_decode.sv
// Purpose: fetch one instruction word from memory into ir and present its decoded fields.
// Latency: 1 cycle from mem_ready to dec_valid; timeout after MEM_TIMEOUT+1 unanswered FETCH cycles.
// Backpressure: ir/dec_valid hold until dec_ready; a new fetch may start in the same cycle it is taken.
module ir_fetch_decode
    import lc3_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    ir_fetch_decode_if.slave   bus
);
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    fetch_state_e     state_q, state_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic             mem_rd_q, mem_rd_d;
    logic [15:0]      ir_q, ir_d;
    logic             dec_valid_q, dec_valid_d;
    logic             fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        ir_d        = ir_q;
        dec_valid_d = dec_valid_q;
        fetch_err_d = 1'b0;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.fetch_req) begin
                    mem_addr_d = bus.pc;
                    mem_rd_d   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Data arriving in the timeout cycle still wins over the error.
                if (bus.mem_ready) begin
                    ir_d        = bus.mem_rdata;
                    mem_rd_d    = 1'b0;
                    dec_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (wait_cnt_q == CNT_MAX) begin
                    fetch_err_d = 1'b1;
                    mem_rd_d    = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.dec_ready) begin
                    dec_valid_d = 1'b0;
                    if (bus.fetch_req) begin
                        mem_addr_d = bus.pc;
                        mem_rd_d   = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_rd_d    = 1'b0;
                dec_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            ir_q        <= '0;
            dec_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            ir_q        <= ir_d;
            dec_valid_q <= dec_valid_d;
            fetch_err_q <= fetch_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.ir        = ir_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.fetch_err = fetch_err_q;
    assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_HOLD);

    ir_field_split u_split (
        .ir         (ir_q),
        .opcode     (bus.opcode),
        .dr         (bus.dr),
        .nzp        (bus.nzp),
        .sr1        (bus.sr1),
        .sr2        (bus.sr2),
        .imm_flag   (bus.imm_flag),
        .imm5       (bus.imm5),
        .offset6    (bus.offset6),
        .pcoffset9  (bus.pcoffset9),
        .pcoffset11 (bus.pcoffset11),
        .trapvect8  (bus.trapvect8)
    );
endmodule

// File: tb/tb_ir_fetch_decode.sv
// Bench for ir_fetch_decode: directed scenarios plus random fetches scored against a queue model.
module tb_ir_fetch_decode;
    import lc3_pkg::*;

    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ir_fetch_decode_if u_if ();

    ir_fetch_decode #(.MEM_TIMEOUT(TMO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_ir = 16'h0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected fields derived arithmetically from the instruction word.
    task automatic chk_fields(input logic [15:0] w);
        int d;
        d = int'(w);
        chk("f_opcode", 32'(u_if.opcode), d / 4096);
        chk("f_dr", 32'(u_if.dr), (d / 512) % 8);
        chk("f_nzp", 32'(u_if.nzp), (d / 512) % 8);
        chk("f_sr1", 32'(u_if.sr1), (d / 64) % 8);
        chk("f_sr2", 32'(u_if.sr2), d % 8);
        chk("f_imm_flag", 32'(u_if.imm_flag), (d / 32) % 2);
        chk("f_imm5", 32'(u_if.imm5), d % 32);
        chk("f_offset6", 32'(u_if.offset6), d % 64);
        chk("f_pcoffset9", 32'(u_if.pcoffset9), d % 512);
        chk("f_pcoffset11", 32'(u_if.pcoffset11), d % 2048);
        chk("f_trapvect8", 32'(u_if.trapvect8), d % 256);
    endtask

    task automatic check_event(input bit is_err);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mon_unexpected: got event err=%0d expected none at %0t", is_err, $time);
        end else begin
            e = exp_q.pop_front();
            chk("mon_kind", 32'(is_err), 32'(e.is_err));
            chk("mon_ir", 32'(u_if.ir), 32'(e.ir));
            if (!is_err) chk_fields(e.ir);
            else chk("mon_err_dv", 32'(u_if.dec_valid), 0);
        end
    endtask

    // Monitor: scores every accepted decode and every error pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (u_if.dec_valid && u_if.dec_ready) check_event(1'b0);
                if (u_if.fetch_err) check_event(1'b1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic start_fetch(input logic [15:0] pc_v);
        u_if.fetch_req = 1'b1;
        u_if.pc        = pc_v;
        u_if.dec_ready = 1'($urandom);
        step();
        u_if.fetch_req = 1'b0;
        u_if.dec_ready = 1'b0;
        chk("sf_busy", 32'(u_if.busy), 1);
        chk("sf_addr", 32'(u_if.mem_addr), 32'(pc_v));
        chk("sf_rd", 32'(u_if.mem_rd), 1);
        chk("sf_dv", 32'(u_if.dec_valid), 0);
    endtask

    // Memory answers after lat idle cycles; more than TMO idle cycles means no answer in time.
    task automatic respond(input logic [15:0] pc_v, input logic [15:0] data, input int lat);
        exp_t e;
        if (lat <= TMO) begin
            e.is_err = 1'b0;
            e.ir     = data;
        end else begin
            e.is_err = 1'b1;
            e.ir     = model_ir;
        end
        exp_q.push_back(e);
        for (int i = 0; i < lat && i <= TMO; i++) begin
            chk("wait_addr", 32'(u_if.mem_addr), 32'(pc_v));
            chk("wait_rd", 32'(u_if.mem_rd), 1);
            chk("wait_err", 32'(u_if.fetch_err), 0);
            u_if.mem_ready = 1'b0;
            u_if.mem_rdata = 16'($urandom);
            u_if.fetch_req = 1'($urandom);
            u_if.pc        = 16'($urandom);
            u_if.dec_ready = 1'($urandom);
            step();
        end
        u_if.fetch_req = 1'b0;
        u_if.dec_ready = 1'b0;
        if (lat <= TMO) begin
            chk("pre_addr", 32'(u_if.mem_addr), 32'(pc_v));
            u_if.mem_ready = 1'b1;
            u_if.mem_rdata = data;
            step();
            u_if.mem_ready = 1'b0;
            u_if.mem_rdata = 16'($urandom);
            model_ir = data;
            chk("cap_dv", 32'(u_if.dec_valid), 1);
            chk("cap_ir", 32'(u_if.ir), 32'(data));
            chk("cap_rd", 32'(u_if.mem_rd), 0);
            chk("cap_err", 32'(u_if.fetch_err), 0);
        end else begin
            chk("to_err", 32'(u_if.fetch_err), 1);
            chk("to_busy", 32'(u_if.busy), 0);
            chk("to_rd", 32'(u_if.mem_rd), 0);
            chk("to_ir", 32'(u_if.ir), 32'(model_ir));
        end
    endtask

    task automatic release_hold(input int hold, input bit b2b, input logic [15:0] nxt_pc);
        for (int i = 0; i < hold; i++) begin
            u_if.dec_ready = 1'b0;
            u_if.fetch_req = 1'($urandom);
            u_if.pc        = 16'($urandom);
            u_if.mem_ready = 1'($urandom);
            u_if.mem_rdata = 16'($urandom);
            step();
            chk("hold_dv", 32'(u_if.dec_valid), 1);
            chk("hold_ir", 32'(u_if.ir), 32'(model_ir));
            chk("hold_busy", 32'(u_if.busy), 1);
        end
        u_if.mem_ready = 1'b0;
        u_if.dec_ready = 1'b1;
        u_if.fetch_req = b2b;
        u_if.pc        = nxt_pc;
        step();
        u_if.dec_ready = 1'b0;
        u_if.fetch_req = 1'b0;
        chk("rel_dv", 32'(u_if.dec_valid), 0);
        chk("rel_busy", 32'(u_if.busy), 32'(b2b));
        if (b2b) begin
            chk("b2b_addr", 32'(u_if.mem_addr), 32'(nxt_pc));
            chk("b2b_rd", 32'(u_if.mem_rd), 1);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_addr", 32'(u_if.mem_addr), 0);
        chk("rst_rd", 32'(u_if.mem_rd), 0);
        chk("rst_ir", 32'(u_if.ir), 0);
        chk("rst_dv", 32'(u_if.dec_valid), 0);
        chk("rst_busy", 32'(u_if.busy), 0);
        chk("rst_err", 32'(u_if.fetch_err), 0);
        chk("rst_opcode", 32'(u_if.opcode), 0);
    endtask

    initial begin
        logic [15:0] cur_pc;
        logic [15:0] nxt_pc;
        bit          in_fetch;
        bit          b2b;
        int          lat;
        int          r;

        u_if.fetch_req = 1'b0;
        u_if.pc        = 16'h0;
        u_if.mem_rdata = 16'h0;
        u_if.mem_ready = 1'b0;
        u_if.dec_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset_state();

        // Basic fetch of an ADD with immediate.
        start_fetch(16'h3000);
        respond(16'h3000, 16'h1261, 2);
        chk("add_opcode", 32'(u_if.opcode), 32'(OP_ADD));
        chk("add_dr", 32'(u_if.dr), 1);
        chk("add_sr1", 32'(u_if.sr1), 1);
        chk("add_imm_flag", 32'(u_if.imm_flag), 1);
        chk("add_imm5", 32'(u_if.imm5), 1);

        // Backpressure for 5 cycles, then single-pulse release to IDLE.
        release_hold(5, 1'b0, 16'h0);

        // Back-to-back fetch.
        start_fetch(16'h3000);
        respond(16'h3000, 16'h5042, 0);
        release_hold(1, 1'b1, 16'h3001);
        respond(16'h3001, 16'h0E05, 1);
        release_hold(0, 1'b0, 16'h0);

        // Timeout with no answer; error lasts exactly one cycle.
        start_fetch(16'h5000);
        respond(16'h5000, 16'hDEAD, TMO + 1);
        step();
        chk("to_pulse_once", 32'(u_if.fetch_err), 0);
        chk("to_idle", 32'(u_if.busy), 0);
        chk("to_ir_kept", 32'(u_if.ir), 32'(model_ir));

        // Answer in the timeout cycle itself.
        start_fetch(16'h5001);
        respond(16'h5001, 16'hF025, TMO);
        chk("tie_opcode", 32'(u_if.opcode), 32'(OP_TRAP));
        chk("tie_trapvect8", 32'(u_if.trapvect8), 32'h25);
        release_hold(0, 1'b0, 16'h0);

        // Reset mid-FETCH with data presented in the reset cycle.
        start_fetch(16'h4000);
        step();
        step();
        rst = 1'b1;
        u_if.mem_ready = 1'b1;
        u_if.mem_rdata = 16'h1234;
        step();
        u_if.mem_ready = 1'b0;
        step();
        rst = 1'b0;
        model_ir = 16'h0;
        chk_reset_state();
        step();
        chk("rst_stay_idle", 32'(u_if.busy), 0);
        chk("rst_no_err", 32'(u_if.fetch_err), 0);

        // Reset mid-HOLD drops the pending decode.
        start_fetch(16'h4100);
        respond(16'h4100, 16'h6ABC, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        model_ir = 16'h0;
        chk_reset_state();

        // Randomized traffic.
        in_fetch = 1'b0;
        cur_pc   = 16'h0;
        for (int n = 0; n < 40; n++) begin
            if (!in_fetch) begin
                cur_pc = 16'($urandom);
                start_fetch(cur_pc);
            end
            r = $urandom_range(0, 9);
            if (r < 6)      lat = $urandom_range(0, 4);
            else if (r < 8) lat = $urandom_range(TMO - 2, TMO);
            else            lat = TMO + 1;
            respond(cur_pc, 16'($urandom), lat);
            if (lat <= TMO) begin
                b2b    = 1'($urandom);
                nxt_pc = 16'($urandom);
                release_hold($urandom_range(0, 3), b2b, nxt_pc);
                in_fetch = b2b;
                cur_pc   = nxt_pc;
            end else begin
                in_fetch = 1'b0;
            end
            if (!in_fetch && r[0]) step();
        end
        if (in_fetch) begin
            respond(cur_pc, 16'($urandom), 0);
            release_hold(0, 1'b0, 16'h0);
        end
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
